// File: rtl/axi_stream_mem_writer_pkg.sv
// Shared types and helpers for the AXI-Stream to AXI4 memory writer.
// The 4 KiB burst limit is enabled with AXI_STREAM_MEM_WRITER_4K_SPLIT_EN.
package axi_stream_mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Beats left before the next 4 KiB boundary for a beat-aligned address.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                              input int unsigned byte_shift);
    logic [12:0] bytes_left;
    bytes_left = 13'd4096 - {1'b0, addr_lo};
    return bytes_left >> byte_shift;
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst length: min of remaining beats and MAX_BURST_LEN, and
// the 4 KiB boundary limit when AXI_STREAM_MEM_WRITER_4K_SPLIT_EN is defined.
module axi_burst_len_calc
  import axi_stream_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int BYTE_SHIFT    = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] remaining,
  output logic [8:0]            len
);

  logic unused_addr;
  assign unused_addr = ^addr;

`ifdef AXI_STREAM_MEM_WRITER_4K_SPLIT_EN
  logic [12:0] lim_4k;
  assign lim_4k = beats_to_4k(addr[11:0], BYTE_SHIFT);
`endif

  always_comb begin
    len = 9'(MAX_BURST_LEN);
    if (remaining < ADDR_WIDTH'(MAX_BURST_LEN)) len = remaining[8:0];
`ifdef AXI_STREAM_MEM_WRITER_4K_SPLIT_EN
    if (lim_4k < {4'b0, len}) len = lim_4k[8:0];
`endif
  end

endmodule

// File: rtl/axi_stream_mem_writer.sv
// Writes a commanded AXIS transfer to memory as AXI4 INCR bursts, one burst
// in flight. Optional 4 KiB splitting: AXI_STREAM_MEM_WRITER_4K_SPLIT_EN.
module axi_stream_mem_writer
  import axi_stream_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int STREAM_WIDTH  = 32,
  parameter int MAX_BURST_LEN = 16,
  localparam int STRB_WIDTH   = STREAM_WIDTH / 8,
  localparam int BYTE_SHIFT   = $clog2(STRB_WIDTH)
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_avalid,
  output logic                    s_aready,
  input  logic [ADDR_WIDTH-1:0]   s_aaddr,
  input  logic [ADDR_WIDTH-1:0]   s_abeats,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_tstrb,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [STREAM_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  output logic                    busy,
  output logic                    error
);

  // Handshakes: a transfer happens on a rising aclk edge where valid && ready;
  // a valid, once raised, holds its payload stable until that edge.

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, rem_q, awaddr_q;
  logic [7:0]              awlen_q;
  logic [8:0]              len_q, beat_cnt_q, calc_len;
  logic                    awvalid_q, busy_q, error_q;
  logic [ADDR_WIDTH-1:0]   calc_addr, calc_rem, next_addr, aligned_addr;
  logic                    accept, w_hs, b_hs, load_aw;
  logic                    unused_bresp;

  assign unused_bresp = m_axi_bresp[0];
  assign aligned_addr = s_aaddr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign next_addr    = addr_q + (ADDR_WIDTH'(len_q) << BYTE_SHIFT);

  assign accept  = (state_q == IDLE) && s_avalid;
  assign w_hs    = (state_q == DATA) && s_axis_tvalid && m_axi_wready;
  assign b_hs    = (state_q == RESP) && m_axi_bvalid;
  assign load_aw = (accept && (s_abeats != '0)) || (b_hs && (rem_q != '0));

  // The next burst is sized from the values that will be live in ADDR.
  always_comb begin
    calc_addr = next_addr;
    calc_rem  = rem_q;
    if (state_q == IDLE) begin
      calc_addr = aligned_addr;
      calc_rem  = s_abeats;
    end
  end

  axi_burst_len_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .BYTE_SHIFT    (BYTE_SHIFT)
  ) u_len_calc (
    .addr      (calc_addr),
    .remaining (calc_rem),
    .len       (calc_len)
  );

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_aready      = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      IDLE: begin
        s_aready = 1'b1;
        if (s_avalid && (s_abeats != '0)) state_d = ADDR;
      end
      ADDR: if (m_axi_awready) state_d = DATA;
      DATA: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        if (s_axis_tvalid && m_axi_wready && (beat_cnt_q == 9'd1)) state_d = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = (rem_q == '0) ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      rem_q      <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      awvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) busy_q <= s_avalid;
      if (accept) begin
        addr_q  <= aligned_addr;
        rem_q   <= s_abeats;
        error_q <= 1'b0;
      end
      if (load_aw) begin
        awaddr_q  <= calc_addr;
        awlen_q   <= 8'(calc_len - 9'd1);
        len_q     <= calc_len;
        awvalid_q <= 1'b1;
      end
      if ((state_q == ADDR) && m_axi_awready) begin
        awvalid_q  <= 1'b0;
        beat_cnt_q <= len_q;
      end
      if (w_hs) begin
        beat_cnt_q <= beat_cnt_q - 9'd1;
        rem_q      <= rem_q - 1'b1;
        // tlast must mark exactly the final beat of the whole transfer.
        if (s_axis_tlast != (rem_q == ADDR_WIDTH'(1))) error_q <= 1'b1;
      end
      if (b_hs) begin
        addr_q <= next_addr;
        if (m_axi_bresp[1]) error_q <= 1'b1;
        if (rem_q == '0)    busy_q  <= 1'b0;
      end
    end
  end

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BYTE_SHIFT);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = s_axis_tstrb;
  assign m_axi_wlast   = (state_q == DATA) && (beat_cnt_q == 9'd1);
  assign busy          = busy_q;
  assign error         = error_q;

endmodule

// File: tb/tb_axi_stream_mem_writer.sv
// Randomised self-checking bench for axi_stream_mem_writer; the expected
// burst list and beat order are derived from the command by plain arithmetic.
module tb_axi_stream_mem_writer;
  import axi_stream_mem_writer_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int MAXB  = 16;
  localparam int EXP_W = 1 + SW + DW;

  logic          aclk, resetn;
  logic          s_avalid, s_aready;
  logic [AW-1:0] s_aaddr, s_abeats;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          busy, error;

  axi_stream_mem_writer dut (
    .aclk(aclk), .resetn(resetn),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr), .s_abeats(s_abeats),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .busy(busy), .error(error)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // scoreboard
  logic [AW+7:0]    exp_aw_q[$];
  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       exp_b_q[$];
  logic [DW-1:0]    st_data_q[$];
  logic [SW-1:0]    st_strb_q[$];
  logic             st_last_q[$];
  logic             exp_err;
  bit               stall, t_taken, b_taken, aw_hold;
  int               pend_b, b_seen, n_bursts;
  logic [AW-1:0]    aw_prev_addr;
  logic [7:0]       aw_prev_len;

  task automatic idle_inputs();
    s_avalid = 0; s_aaddr = '0; s_abeats = '0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tstrb = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = AXI_RESP_OKAY;
  endtask

  task automatic clear_model();
    exp_aw_q.delete(); exp_q.delete(); exp_b_q.delete();
    st_data_q.delete(); st_strb_q.delete(); st_last_q.delete();
    pend_b = 0; b_seen = 0; n_bursts = 0;
    t_taken = 0; b_taken = 0; aw_hold = 0; exp_err = 0;
  endtask

  // Reference: split the aligned transfer into bursts and list beats in order.
  task automatic build_model(input logic [AW-1:0] addr, input int beats,
                             input int tlast_pos, input int err_burst);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int rem, len, bidx, beat;
    a = addr & ~AW'(SW - 1);
    rem = beats; bidx = 0; beat = 0;
    exp_err = (beats != 0) && (tlast_pos != beats);
    while (rem > 0) begin
      len = (rem < MAXB) ? rem : MAXB;
`ifdef AXI_STREAM_MEM_WRITER_4K_SPLIT_EN
      if ((4096 - int'(a[11:0])) / SW < len) len = (4096 - int'(a[11:0])) / SW;
`endif
      exp_aw_q.push_back({a, 8'(len - 1)});
      exp_b_q.push_back((bidx == err_burst) ? 2'b10 : AXI_RESP_OKAY);
      if (bidx == err_burst) exp_err = 1;
      for (int i = 0; i < len; i++) begin
        d = $urandom; s = SW'($urandom); beat++;
        st_data_q.push_back(d); st_strb_q.push_back(s); st_last_q.push_back(beat == tlast_pos);
        exp_q.push_back({(i == len - 1), s, d});
      end
      a = a + AW'(len * SW);
      rem -= len; bidx++;
    end
    n_bursts = bidx;
  endtask

  // driver: one clock of stream/AXI-slave activity, then observe handshakes
  task automatic drive_cycle();
    logic [AW+7:0]    e_aw;
    logic [EXP_W-1:0] e_w;
    @(negedge aclk);
    if (t_taken) begin s_axis_tvalid = 0; t_taken = 0; end
    if (!s_axis_tvalid && st_data_q.size() > 0 && (!stall || $urandom_range(0, 3) != 0)) begin
      s_axis_tvalid = 1; s_axis_tdata = st_data_q[0];
      s_axis_tstrb = st_strb_q[0]; s_axis_tlast = st_last_q[0];
    end
    m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (b_taken) begin m_axi_bvalid = 0; b_taken = 0; end
    if (!m_axi_bvalid && pend_b > 0 && exp_b_q.size() > 0 && (!stall || $urandom_range(0, 1) != 0)) begin
      m_axi_bvalid = 1; m_axi_bresp = exp_b_q[0];
    end
    #1;
    if (aw_hold) begin
      checks++;
      if (!m_axi_awvalid || m_axi_awaddr !== aw_prev_addr || m_axi_awlen !== aw_prev_len) begin
        errors++;
        $display("FAIL aw_stable: got v=%b addr=%h len=%0d, expected v=1 addr=%h len=%0d",
                 m_axi_awvalid, m_axi_awaddr, m_axi_awlen, aw_prev_addr, aw_prev_len);
      end
    end
    aw_hold = m_axi_awvalid && !m_axi_awready;
    aw_prev_addr = m_axi_awaddr; aw_prev_len = m_axi_awlen;
    if (m_axi_awvalid && m_axi_awready) begin
      checks++;
      if (exp_aw_q.size() == 0) begin
        errors++;
        $display("FAIL aw_extra: got addr=%h len=%0d, expected no burst", m_axi_awaddr, m_axi_awlen);
      end else begin
        e_aw = exp_aw_q.pop_front();
        if ({m_axi_awaddr, m_axi_awlen} !== e_aw || m_axi_awsize !== 3'($clog2(SW)) ||
            m_axi_awburst !== AXI_BURST_INCR) begin
          errors++;
          $display("FAIL aw_burst: got addr=%h len=%0d size=%0d burst=%b, expected addr=%h len=%0d size=%0d burst=01",
                   m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, e_aw[AW+7:8], e_aw[7:0], $clog2(SW));
        end
      end
    end
    checks++;
    if ((s_axis_tvalid && s_axis_tready) !== (m_axi_wvalid && m_axi_wready)) begin
      errors++;
      $display("FAIL hs_pass: got stream_hs=%b, expected equal to w_hs=%b",
               s_axis_tvalid && s_axis_tready, m_axi_wvalid && m_axi_wready);
    end
    if (m_axi_wvalid && m_axi_wready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL w_extra: got data=%h, expected no beat", m_axi_wdata);
      end else begin
        e_w = exp_q.pop_front();
        if ({m_axi_wlast, m_axi_wstrb, m_axi_wdata} !== e_w) begin
          errors++;
          $display("FAIL w_beat: got last=%b strb=%h data=%h, expected last=%b strb=%h data=%h",
                   m_axi_wlast, m_axi_wstrb, m_axi_wdata, e_w[EXP_W-1], e_w[EXP_W-2:DW], e_w[DW-1:0]);
        end
      end
      if (st_data_q.size() > 0) begin
        void'(st_data_q.pop_front()); void'(st_strb_q.pop_front()); void'(st_last_q.pop_front());
      end
      t_taken = 1;
      if (m_axi_wlast) pend_b++;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
      pend_b--; b_seen++; b_taken = 1;
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] addr, input int beats);
    @(negedge aclk);
    idle_inputs();
    s_avalid = 1; s_aaddr = addr; s_abeats = AW'(beats);
    #1;
    checks++;
    if (s_aready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready: got s_aready=%b, expected 1", s_aready);
    end
    @(negedge aclk);
    s_avalid = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL cmd_accept: got busy=%b error=%b, expected busy=1 error=0", busy, error);
    end
  endtask

  task automatic run_transfer(input logic [AW-1:0] addr, input int beats, input int tlast_pos,
                              input int err_burst, input bit stl);
    bit done;
    clear_model();
    stall = stl;
    build_model(addr, beats, tlast_pos, err_burst);
    issue_cmd(addr, beats);
    done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      done = (exp_aw_q.size() == 0) && (exp_q.size() == 0) && (b_seen == n_bursts) && (pend_b == 0);
      if (!done) drive_cycle();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got aw_left=%0d w_left=%0d b_seen=%0d, expected 0 0 %0d",
               exp_aw_q.size(), exp_q.size(), b_seen, n_bursts);
    end
    @(negedge aclk);
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0 || error !== exp_err || s_aready !== 1'b1) begin
      errors++;
      $display("FAIL end_state: got busy=%b error=%b aready=%b, expected busy=0 error=%b aready=1",
               busy, error, s_aready, exp_err);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (m_axi_awvalid !== 0 || m_axi_wvalid !== 0 || s_axis_tready !== 0 || m_axi_bready !== 0 ||
        busy !== 0 || error !== 0 || s_aready !== 1 || m_axi_wlast !== 0) begin
      errors++;
      $display("FAIL %s: got awv=%b wv=%b tr=%b br=%b busy=%b err=%b ar=%b wl=%b, expected 0 0 0 0 0 0 1 0",
               tag, m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy, error, s_aready, m_axi_wlast);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); clear_model();
    resetn = 0;
    repeat (3) @(negedge aclk);
    #1 check_reset_outputs("reset");
    @(negedge aclk);
    resetn = 1;
    #1 check_reset_outputs("post_reset");
  endtask

  task automatic test_single();
    run_transfer(32'h0000_1000, 3, 3, -1, 0);
  endtask

  task automatic test_multi_burst();
    run_transfer(32'h0000_0000, 40, 40, -1, 0);
  endtask

  task automatic test_4k_boundary();
    run_transfer(32'h0000_0FF8, 8, 8, -1, 0);
  endtask

  task automatic test_random_stalls();
    logic [AW-1:0] a;
    int n;
    for (int k = 0; k < 8; k++) begin
      a = (k == 7) ? 32'hFFFF_FFF1 : ($urandom & 32'h0000_3FFF);
      n = $urandom_range(1, 50);
      run_transfer(a, n, n, -1, 1);
    end
  endtask

  task automatic test_bresp_error();
    run_transfer(32'h0000_0400, 40, 40, 1, 1);
    run_transfer(32'h0000_0800, 2, 2, -1, 0);
  endtask

  task automatic test_tlast_error();
    run_transfer(32'h0000_0200, 4, 2, -1, 0);
  endtask

  task automatic test_zero_beats();
    clear_model();
    issue_cmd(32'h0000_3000, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1; s_axis_tdata = $urandom; m_axi_awready = 1; m_axi_wready = 1;
      #1;
      checks++;
      if (m_axi_awvalid !== 0 || s_axis_tready !== 0 || busy !== 0 || s_aready !== 1) begin
        errors++;
        $display("FAIL zero_beats: got awv=%b tready=%b busy=%b aready=%b, expected 0 0 0 1",
                 m_axi_awvalid, s_axis_tready, busy, s_aready);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_data();
    clear_model();
    stall = 0;
    build_model(32'h0000_2000, 10, 10, -1);
    issue_cmd(32'h0000_2000, 10);
    for (int cyc = 0; cyc < 50 && exp_q.size() > 8; cyc++) drive_cycle();
    checks++;
    if (exp_q.size() > 8) begin
      errors++; $display("FAIL mid_data_reach: got w_left=%0d, expected <=8", exp_q.size());
    end
    #2 resetn = 0;
    #1 check_reset_outputs("reset_mid_data");
    @(negedge aclk);
    idle_inputs(); clear_model();
    resetn = 1;
    run_transfer(32'h0000_5004, 5, 5, -1, 1);
  endtask

  initial begin
    resetn = 0;
    stall = 0;
    test_reset();
    test_single();
    test_multi_burst();
    test_4k_boundary();
    test_random_stalls();
    test_bresp_error();
    test_tlast_error();
    test_zero_beats();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
